// File: rtl/gamepad_serial_reader.sv
// Latch/clock serial reader for two shift-register gamepads sharing latch and clock.
// Each request latches both pads, shifts BUTTON_COUNT bits and presents both words with a valid strobe.
module gamepad_serial_reader #(
    parameter int BUTTON_COUNT = 12,
    parameter int CLK_DIV      = 4,
    parameter int SYNC_INPUTS  = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    valid,
    output logic                    pad_latch,
    output logic                    pad_clk,
    input  logic [1:0]              pad_data,
    output logic [BUTTON_COUNT-1:0] p1_btn,
    output logic [BUTTON_COUNT-1:0] p2_btn
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = (BUTTON_COUNT > 1) ? $clog2(BUTTON_COUNT) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LATCH = 3'd1;
    localparam logic [2:0] LOW   = 3'd2;
    localparam logic [2:0] HIGH  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]              state;
    logic [DW-1:0]           div_cnt;
    logic [IW-1:0]           idx;
    logic [BUTTON_COUNT-1:0] sh1, sh2, cap1, cap2;
    logic [1:0]              data_s;
    logic                    div_end, last_bit;

    generate
        if (SYNC_INPUTS != 0) begin : g_sync
            logic [1:0] s0, s1;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s0 <= '0;
                    s1 <= '0;
                end else begin
                    s0 <= pad_data;
                    s1 <= s0;
                end
            end
            assign data_s = s1;
        end else begin : g_nosync
            assign data_s = pad_data;
        end
    endgenerate

    assign div_end  = (div_cnt == DW'(CLK_DIV - 1));
    assign last_bit = (idx == IW'(BUTTON_COUNT - 1));

    // Shift words with the current bit merged in, so the last bit can go straight to the outputs.
    always_comb begin
        cap1      = sh1;
        cap2      = sh2;
        cap1[idx] = data_s[0];
        cap2[idx] = data_s[1];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            idx       <= '0;
            sh1       <= '0;
            sh2       <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            p1_btn    <= '0;
            p2_btn    <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    pad_latch <= 1'b0;
                    pad_clk   <= 1'b0;
                    busy      <= 1'b0;
                    if (start) begin
                        state     <= LATCH;
                        div_cnt   <= '0;
                        idx       <= '0;
                        sh1       <= '0;
                        sh2       <= '0;
                        busy      <= 1'b1;
                        pad_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (div_end) begin
                        state     <= LOW;
                        div_cnt   <= '0;
                        pad_latch <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sh1     <= cap1;
                        sh2     <= cap2;
                        if (last_bit) begin
                            state  <= DONE;
                            p1_btn <= cap1;
                            p2_btn <= cap2;
                            valid  <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state   <= HIGH;
                            pad_clk <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_end) begin
                        state   <= LOW;
                        div_cnt <= '0;
                        pad_clk <= 1'b0;
                        idx     <= idx + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gamepad_serial_reader.sv
// Directed bench: default-parameter reader plus a CLK_DIV=7/8-button/unsynchronized instance,
// each answered by behavioural shift-register pads.
module tb_gamepad_serial_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Instance A: defaults
    logic        rst_a = 1'b0, start_a = 1'b0;
    logic        busy_a, valid_a, latch_a, pclk_a;
    logic [1:0]  data_a;
    logic [11:0] p1_a, p2_a;
    logic [11:0] w_a1 = '0, w_a2 = '0, m_a1 = '0, m_a2 = '0;
    logic        pc_a = 1'b0;

    gamepad_serial_reader dut_a (
        .clk(clk), .reset_n(rst_a), .start(start_a), .busy(busy_a), .valid(valid_a),
        .pad_latch(latch_a), .pad_clk(pclk_a), .pad_data(data_a), .p1_btn(p1_a), .p2_btn(p2_a)
    );

    always @(posedge clk) begin
        pc_a <= pclk_a;
        if (latch_a) begin
            m_a1 <= w_a1;
            m_a2 <= w_a2;
        end else if (pclk_a && !pc_a) begin
            m_a1 <= m_a1 >> 1;
            m_a2 <= m_a2 >> 1;
        end
    end
    assign data_a = {m_a2[0], m_a1[0]};

    // Instance B: parameter sweep
    logic       rst_b = 1'b0, start_b = 1'b0;
    logic       busy_b, valid_b, latch_b, pclk_b;
    logic [1:0] data_b;
    logic [7:0] p1_b, p2_b;
    logic [7:0] w_b1 = 8'h81, w_b2 = 8'h7E, m_b1 = '0, m_b2 = '0;
    logic       pc_b = 1'b0;

    gamepad_serial_reader #(.BUTTON_COUNT(8), .CLK_DIV(7), .SYNC_INPUTS(0)) dut_b (
        .clk(clk), .reset_n(rst_b), .start(start_b), .busy(busy_b), .valid(valid_b),
        .pad_latch(latch_b), .pad_clk(pclk_b), .pad_data(data_b), .p1_btn(p1_b), .p2_btn(p2_b)
    );

    always @(posedge clk) begin
        pc_b <= pclk_b;
        if (latch_b) begin
            m_b1 <= w_b1;
            m_b2 <= w_b2;
        end else if (pclk_b && !pc_b) begin
            m_b1 <= m_b1 >> 1;
            m_b2 <= m_b2 >> 1;
        end
    end
    assign data_b = {m_b2[0], m_b1[0]};

    logic [11:0] mid1, mid2;

    // Caller sits on a negedge; start is sampled at the next posedge (E0), cycle 1 follows it.
    task automatic run_a(output int vcyc, output int nclk, output int nlat);
        logic pc;
        vcyc = 0; nclk = 0; nlat = 0; pc = 1'b0;
        start_a = 1'b1;
        for (int cyc = 1; cyc <= 400 && vcyc == 0; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (latch_a) nlat++;
            if (pclk_a && !pc) nclk++;
            pc = pclk_a;
            if (cyc == 50) begin
                mid1 = p1_a;
                mid2 = p2_a;
            end
            if (valid_a) vcyc = cyc;
        end
    endtask

    initial begin
        int vcyc, nclk, nlat, cnt, last_v, last_l, nv;
        logic pl;

        // Reset held with start asserted
        start_a = 1'b1;
        start_b = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_outs_a", {busy_a, valid_a, latch_a, pclk_a, p1_a, p2_a}, 0);
        chk("reset_outs_b", {busy_b, valid_b, latch_b, pclk_b, p1_b, p2_b}, 0);
        start_a = 1'b0;
        start_b = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (latch_a || pclk_a || valid_a || busy_a) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        // Basic read
        w_a1 = 12'hA5C;
        w_a2 = 12'h3F1;
        run_a(vcyc, nclk, nlat);
        chk("basic_valid_cyc", vcyc, 97);
        chk("basic_p1", p1_a, 12'hA5C);
        chk("basic_p2", p2_a, 12'h3F1);
        chk("basic_clk_rises", nclk, 11);
        chk("basic_latch_cycles", nlat, 4);
        chk("basic_busy_low", busy_a, 0);

        // Back-to-back: start in the cycle after valid
        @(negedge clk);
        chk("valid_once", valid_a, 0);
        w_a1 = 12'h000;
        w_a2 = 12'hFFF;
        run_a(vcyc, nclk, nlat);
        chk("b2b_hold_p1", mid1, 12'hA5C);
        chk("b2b_hold_p2", mid2, 12'h3F1);
        chk("b2b_valid_cyc", vcyc, 97);
        chk("b2b_p1", p1_a, 12'h000);
        chk("b2b_p2", p2_a, 12'hFFF);
        @(negedge clk);

        // Start held high: one idle cycle between valid and next latch rise, full length each time
        w_a1 = 12'h5A3;
        w_a2 = 12'hC0F;
        start_a = 1'b1;
        last_v = -1; last_l = -1; nv = 0; pl = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (latch_a && !pl) begin
                if (last_v >= 0) chk("hold_gap", cyc - last_v, 2);
                last_l = cyc;
            end
            pl = latch_a;
            if (valid_a) begin
                nv++;
                chk("hold_len", cyc - last_l, 96);
                chk("hold_p1", p1_a, 12'h5A3);
                last_v = cyc;
            end
        end
        start_a = 1'b0;
        chk("hold_count", nv, 3);
        repeat (110) @(negedge clk);

        // Reset mid-transaction
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (39) @(negedge clk);
        chk("mid_busy", busy_a, 1);
        rst_a = 1'b0;
        #1;
        chk("mid_reset_outs", {busy_a, valid_a, latch_a, pclk_a, p1_a, p2_a}, 0);
        repeat (3) @(negedge clk);
        rst_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_idle", {busy_a, latch_a, pclk_a}, 0);
        w_a1 = 12'h9C6;
        w_a2 = 12'h12B;
        run_a(vcyc, nclk, nlat);
        chk("post_reset_cyc", vcyc, 97);
        chk("post_reset_p1", p1_a, 12'h9C6);
        chk("post_reset_p2", p2_a, 12'h12B);

        // Parameter sweep instance
        @(negedge clk);
        start_b = 1'b1;
        vcyc = 0;
        for (int cyc = 1; cyc <= 400 && vcyc == 0; cyc++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (valid_b) vcyc = cyc;
        end
        chk("sweep_valid_cyc", vcyc, 113);
        chk("sweep_p1", p1_b, 8'h81);
        chk("sweep_p2", p2_b, 8'h7E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
